// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard signals exchanged between the datapath and the stall/flush sequencer.
interface hazard_ctrl_if;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic        uses_rs_ID;
  logic        uses_rt_ID;
  logic [1:0]  fp_op_ID;
  logic        MemRead_EXE;
  logic        FP_load_EXE;
  logic [4:0]  Rt_EXE;
  logic        Branch_taken_EXE;
  logic        Jmp_EXE;
  logic        PC_write;
  logic        IFID_write;
  logic        IFID_flush;
  logic        IDEXE_write;
  logic        IDEXE_bubble;
  logic        fp_busy;
  logic [15:0] stall_cycles;

  modport master (
    output Rs_ID, Rt_ID, uses_rs_ID, uses_rt_ID, fp_op_ID,
           MemRead_EXE, FP_load_EXE, Rt_EXE, Branch_taken_EXE, Jmp_EXE,
    input  PC_write, IFID_write, IFID_flush, IDEXE_write, IDEXE_bubble,
           fp_busy, stall_cycles
  );

  modport slave (
    input  Rs_ID, Rt_ID, uses_rs_ID, uses_rt_ID, fp_op_ID,
           MemRead_EXE, FP_load_EXE, Rt_EXE, Branch_taken_EXE, Jmp_EXE,
    output PC_write, IFID_write, IFID_flush, IDEXE_write, IDEXE_bubble,
           fp_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirect squash, FP mul/div EXE
// occupancy and load-use bubbles, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int FP_MUL_LAT = 4,
  parameter int FP_DIV_LAT = 12
) (
  input  logic         Clk,
  input  logic         Rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, FP_BUSY} state_t;

  localparam logic [3:0] MUL_INIT = 4'(FP_MUL_LAT - 1);
  localparam logic [3:0] DIV_INIT = 4'(FP_DIV_LAT - 1);

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic [15:0] stall_cnt;
  logic        redirect, load_use_hit;
  logic        pc_write, ifid_write, ifid_flush, idexe_write, idexe_bubble, fp_busy;

  // A load into integer $0 never creates a dependency, but FP $f0 is a real register.
  assign redirect     = hz.Branch_taken_EXE | hz.Jmp_EXE;
  assign load_use_hit = hz.MemRead_EXE & ((hz.Rt_EXE != 5'd0) | hz.FP_load_EXE) &
                        ((hz.uses_rs_ID & (hz.Rs_ID == hz.Rt_EXE)) |
                         (hz.uses_rt_ID & (hz.Rt_ID == hz.Rt_EXE)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idexe_write  = 1'b1;
    idexe_bubble = 1'b0;
    fp_busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          ifid_flush   = 1'b1;
          idexe_bubble = 1'b1;
        end else if (load_use_hit) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idexe_bubble = 1'b1;
        end else if (hz.fp_op_ID == 2'b10) begin
          next_state = FP_BUSY;
          next_cnt   = MUL_INIT;
        end else if (hz.fp_op_ID == 2'b11) begin
          next_state = FP_BUSY;
          next_cnt   = DIV_INIT;
        end
      end
      FP_BUSY: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idexe_write = 1'b0;
        fp_busy     = 1'b1;
        // The issue cycle already counted as one EXE cycle, so leave once cnt reaches 1.
        if (cnt <= 4'd1) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
    if (Rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idexe_write  = 1'b1;
      idexe_bubble = 1'b1;
      fp_busy      = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt <= 16'd0;
    end else if (!pc_write && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign hz.PC_write     = pc_write;
  assign hz.IFID_write   = ifid_write;
  assign hz.IFID_flush   = ifid_flush;
  assign hz.IDEXE_write  = idexe_write;
  assign hz.IDEXE_bubble = idexe_bubble;
  assign hz.fp_busy      = fp_busy;
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: reset, load-use, FP occupancy, redirect priority,
// mid-operation reset and stall counter saturation.
module tb_hazard_ctrl;

  // Output vector order: {PC_write, IFID_write, IFID_flush, IDEXE_write, IDEXE_bubble, fp_busy}
  localparam logic [5:0] V_RESET  = 6'b001110;
  localparam logic [5:0] V_NORMAL = 6'b110100;
  localparam logic [5:0] V_LOADUSE = 6'b000110;
  localparam logic [5:0] V_BUSY   = 6'b000001;
  localparam logic [5:0] V_REDIR  = 6'b111110;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl #(.FP_MUL_LAT(4), .FP_DIV_LAT(12)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (hz.slave)
  );

  always #5 Clk = ~Clk;

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                               input logic urt, input logic [1:0] fpop, input logic mr,
                               input logic fpl, input logic [4:0] rte, input logic br,
                               input logic jmp);
    hz.Rs_ID            = rs;
    hz.Rt_ID            = rt;
    hz.uses_rs_ID       = urs;
    hz.uses_rt_ID       = urt;
    hz.fp_op_ID         = fpop;
    hz.MemRead_EXE      = mr;
    hz.FP_load_EXE      = fpl;
    hz.Rt_EXE           = rte;
    hz.Branch_taken_EXE = br;
    hz.Jmp_EXE          = jmp;
  endtask

  task automatic applyIdle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples on the negedge, where the pipeline registers would see the controls.
  task automatic checkVec(input string tag, input logic [5:0] exp);
    @(negedge Clk);
    checkOutput(tag, {10'd0, hz.PC_write, hz.IFID_write, hz.IFID_flush,
                      hz.IDEXE_write, hz.IDEXE_bubble, hz.fp_busy}, {10'd0, exp});
  endtask

  task automatic checkStall(input string tag, input logic [15:0] exp);
    checkOutput(tag, hz.stall_cycles, exp);
  endtask

  initial begin
    applyIdle();
    Rst = 1'b1;
    checkVec("reset_out_1", V_RESET);
    next_cycle();
    checkVec("reset_out_2", V_RESET);
    checkStall("reset_stall", 16'd0);
    next_cycle();
    Rst = 1'b0;
    checkVec("normal_after_reset", V_NORMAL);
    next_cycle();
    checkStall("stall_after_normal", 16'd0);

    // Integer load-use on Rs
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
    checkVec("loaduse_rs", V_LOADUSE);
    next_cycle();
    applyIdle();
    checkVec("loaduse_rs_release", V_NORMAL);
    checkStall("stall_loaduse_rs", 16'd1);

    // Integer load to $0 is no hazard
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkVec("load_r0_nostall", V_NORMAL);
    next_cycle();
    checkStall("stall_load_r0", 16'd1);

    // FP load to $f0 is a hazard
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    checkVec("load_f0_stall", V_LOADUSE);
    next_cycle();

    // Match on Rt but Rt unused: no hazard; then Rt used: hazard
    applyStimulus(5'd1, 5'd9, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
    checkVec("rt_unused_nostall", V_NORMAL);
    next_cycle();
    applyStimulus(5'd1, 5'd9, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
    checkVec("loaduse_rt", V_LOADUSE);
    next_cycle();
    applyIdle();
    checkStall("stall_after_rt", 16'd3);

    // FP multiply: 3 busy cycles
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkVec("mul_issue", V_NORMAL);
    next_cycle();
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      checkVec($sformatf("mul_busy_%0d", i), V_BUSY);
      next_cycle();
    end
    checkVec("mul_done", V_NORMAL);
    checkStall("stall_after_mul", 16'd6);
    next_cycle();

    // FP divide: 11 busy cycles
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkVec("div_issue", V_NORMAL);
    next_cycle();
    applyIdle();
    for (int i = 0; i < 11; i++) begin
      checkVec($sformatf("div_busy_%0d", i), V_BUSY);
      next_cycle();
    end
    checkVec("div_done", V_NORMAL);
    checkStall("stall_after_div", 16'd17);
    next_cycle();

    // Redirect beats load-use and blocks FP entry
    applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    checkVec("branch_priority", V_REDIR);
    next_cycle();
    applyIdle();
    checkVec("branch_no_fpbusy", V_NORMAL);
    checkStall("stall_after_branch", 16'd17);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    checkVec("jump_redirect", V_REDIR);
    next_cycle();
    applyIdle();
    checkVec("jump_no_fpbusy", V_NORMAL);
    next_cycle();

    // Reset on the 5th EXE cycle of a divide
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    applyIdle();
    for (int i = 0; i < 3; i++) next_cycle();
    checkVec("div_before_reset", V_BUSY);
    Rst = 1'b1;
    checkVec("reset_mid_div", V_RESET);
    next_cycle();
    Rst = 1'b0;
    checkVec("idle_after_mid_reset", V_NORMAL);
    checkStall("stall_after_mid_reset", 16'd0);
    next_cycle();

    // Held load-use hazard drives the counter to saturation
    applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) next_cycle();
    checkStall("stall_fffe", 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checkStall($sformatf("stall_sat_%0d", i), 16'hFFFF);
    end
    applyIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage MIPS integer+FP pipeline.
- Computes write-enables and squash controls for PC, IF/ID and ID/EXE each cycle.
- Three sources, in priority order: control redirects from EXE, multi-cycle FP mul/div occupancy of EXE, and load-use hazards.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- FP_MUL_LAT, 4, EXE occupancy in cycles of an FP multiply (must be >= 2).
- FP_DIV_LAT, 12, EXE occupancy in cycles of an FP divide (must be >= 2, <= 15).

Ports:
- Clk  input  1  clock; state updates on posedge; outputs settle before the negedge at which the pipeline registers sample.
- Rst  input  1  reset; synchronous, active-high.
- Rs_ID  input  5  source register 1 of the instruction in ID.
- Rt_ID  input  5  source register 2 of the instruction in ID.
- uses_rs_ID  input  1  ID instruction reads Rs.
- uses_rt_ID  input  1  ID instruction reads Rt.
- fp_op_ID  input  2  ID instruction class: 00 none/int, 01 FP single-cycle, 10 FP mul, 11 FP div.
- MemRead_EXE  input  1  instruction in EXE is a load.
- FP_load_EXE  input  1  the EXE load targets the FP register file.
- Rt_EXE  input  5  destination register of the EXE load.
- Branch_taken_EXE  input  1  branch resolved taken in EXE.
- Jmp_EXE  input  1  jump or jump-register in EXE.
- PC_write  output  1  PC update enable.
- IFID_write  output  1  IF/ID load enable.
- IFID_flush  output  1  IF/ID loads a NOP.
- IDEXE_write  output  1  ID/EXE load enable.
- IDEXE_bubble  output  1  ID/EXE loads all-zero control signals.
- fp_busy  output  1  FP mul/div is occupying EXE.
- stall_cycles  output  16  count of cycles with PC_write=0.

Behaviour:
- FSM states: IDLE, FP_BUSY. A 4-bit down-counter cnt accompanies FP_BUSY. All outputs are combinational from state, cnt and inputs.

During Rst high (synchronous):
- At the edge: state becomes IDLE, cnt=0, stall_cycles=0.
- Outputs while Rst=1: PC_write=0, IFID_write=0, IFID_flush=1, IDEXE_write=1, IDEXE_bubble=1, fp_busy=0.
- Reset asserted mid-FP_BUSY abandons the operation; no carry-over.

Redirect in IDLE (Branch_taken_EXE|Jmp_EXE):
- Outputs: PC_write=1, IFID_write=1, IFID_flush=1, IDEXE_write=1, IDEXE_bubble=1.
- Overrides load-use detection.
- The ID instruction is squashed, so its fp_op_ID never starts FP_BUSY.

Load-use in IDLE, when there is no redirect:
- hit = MemRead_EXE & (Rt_EXE!=0 | FP_load_EXE) & ((uses_rs_ID & Rs_ID==Rt_EXE) | (uses_rt_ID & Rt_ID==Rt_EXE)).
- Outputs on hit: PC_write=0, IFID_write=0, IFID_flush=0, IDEXE_write=1, IDEXE_bubble=1.
- Exactly one bubble per hazard. Next cycle the load is in MEM and forwarding resolves it.
- A hit suppresses FP_BUSY entry, because the ID instruction did not advance.

Normal flow in IDLE (no redirect, no hit):
- All writes are 1, flush/bubble are 0.
- If fp_op_ID is 10 or 11, at the posedge: state goes to FP_BUSY, and cnt loads FP_MUL_LAT-1 or FP_DIV_LAT-1 respectively.

FP_BUSY:
- Outputs: PC_write=0, IFID_write=0, IDEXE_write=0, IFID_flush=0, IDEXE_bubble=0, fp_busy=1.
- Redirect and load-use inputs are ignored; they cannot arise while the FP op holds EXE.
- cnt decrements each cycle. When cnt==1 at the posedge, the next state is IDLE with cnt=0.
- Total FP_BUSY cycles = LAT-1, so EXE occupancy = LAT cycles including the issue cycle.

Back-to-back:
- A long FP op in ID on the first IDLE cycle after FP_BUSY re-enters FP_BUSY immediately.
- The IDLE cycle itself stalls only if a load-use hit exists.

stall_cycles:
- Increments at each posedge where Rst=0 and PC_write=0.
- Saturates at 16'hFFFF with no wrap.
- Redirect cycles (PC_write=1) do not count.

Test Plan:
- Rst=1 for 2 cycles, then release with no hazards -> during reset PC_write=0, IFID_flush=1, IDEXE_bubble=1, stall_cycles=0; after release all writes are 1 and flush/bubble are 0.
- MemRead_EXE=1, Rt_EXE=5, Rs_ID=5, uses_rs_ID=1 -> one cycle of PC_write=0, IFID_write=0, IDEXE_bubble=1, then normal flow; stall_cycles=1. Repeat with Rt_EXE=0 and FP_load_EXE=0 -> no stall.
- Same as above with Rt_EXE=0 and FP_load_EXE=1 (load to $f0) -> stall occurs.
- fp_op_ID=10 with default parameters -> fp_busy=1 for exactly 3 cycles with PC_write=0 and IDEXE_write=0, then IDLE; stall_cycles=3. fp_op_ID=11 -> 11 cycles.
- Branch_taken_EXE=1 together with a load-use hit and fp_op_ID=11 -> IFID_flush=1, IDEXE_bubble=1, PC_write=1; no FP_BUSY entry and stall_cycles unchanged.
- Rst asserted on the 5th cycle of an FP divide -> at the next edge fp_busy=0 and state is IDLE. Force stall_cycles to 16'hFFFE, then three stall cycles -> counter holds at 16'hFFFF.
